// File: rtl/mem_stage.sv
// MIPS memory stage: word-addressed data RAM, loads/stores, registered WB bundle.
// Optional MEM_SUBWORD_EN adds LB/LBU/LH/LHU/SB/SH (little-endian lanes).
// Ports: CLK, RST (sync, active-low), In_valid, Stall, Ins, Result (byte addr),
//        Rdata2 (store data) -> Out_valid, Wb_data, Wb_reg, Wb_we, Misalign.
module mem_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        In_valid,
  input  logic        Stall,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Out_valid,
  output logic [31:0] Wb_data,
  output logic [4:0]  Wb_reg,
  output logic        Wb_we,
  output logic        Misalign
);
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [5:0]        op;
  logic [4:0]        dest;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic              is_ld;
  logic              is_st;
  logic              wr_rf;
  logic              aligned;
  logic              mis;
  logic              mem_we;
  logic [31:0]       ld_val;
  logic [31:0]       st_word;
  logic              unused_bits;

  logic [31:0] mem_q [2**ADDR_W];

  logic        ov_q, ov_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  reg_q, reg_d;
  logic        we_q, we_d;
  logic        mis_q, mis_d;

  assign op      = Ins[31:26];
  assign dest    = (op == OP_R) ? Ins[15:11] : Ins[20:16];
  assign idx     = Result[ADDR_W+1:2];
  assign rd_word = mem_q[idx];

  assign unused_bits = ^{Ins[25:21], Ins[10:0], Result[31:ADDR_W+2]};

`ifdef MEM_SUBWORD_EN
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  // sz: 0 byte, 1 half, 2 word
  logic [1:0]  sz;
  logic        sgn;
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] bmask;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    wr_rf = 1'b0;
    sz    = 2'd2;
    sgn   = 1'b0;
    unique case (op)
      OP_R, OP_ADDI, OP_ADDIU,
      OP_SLTI, OP_SLTIU: wr_rf = 1'b1;
      OP_LW:  begin is_ld = 1'b1; wr_rf = 1'b1; end
      OP_SW:  is_st = 1'b1;
      OP_LB:  begin
        is_ld = 1'b1; wr_rf = 1'b1; sz = 2'd0; sgn = 1'b1;
      end
      OP_LBU: begin is_ld = 1'b1; wr_rf = 1'b1; sz = 2'd0; end
      OP_LH:  begin
        is_ld = 1'b1; wr_rf = 1'b1; sz = 2'd1; sgn = 1'b1;
      end
      OP_LHU: begin is_ld = 1'b1; wr_rf = 1'b1; sz = 2'd1; end
      OP_SB:  begin is_st = 1'b1; sz = 2'd0; end
      OP_SH:  begin is_st = 1'b1; sz = 2'd1; end
      default: ;
    endcase
  end

  assign sh   = {Result[1:0], 3'b000};
  assign lane = rd_word >> sh;

  always_comb begin
    unique case (sz)
      2'd0: begin
        aligned = 1'b1;
        bmask   = 32'h0000_00FF << sh;
        ld_val  = {{24{sgn & lane[7]}}, lane[7:0]};
      end
      2'd1: begin
        aligned = ~Result[0];
        bmask   = 32'h0000_FFFF << sh;
        ld_val  = {{16{sgn & lane[15]}}, lane[15:0]};
      end
      default: begin
        aligned = (Result[1:0] == 2'b00);
        bmask   = 32'hFFFF_FFFF;
        ld_val  = lane;
      end
    endcase
  end

  // read-modify-write so only addressed lanes change
  assign st_word = (rd_word & ~bmask) | ((Rdata2 << sh) & bmask);
`else
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    wr_rf = 1'b0;
    unique case (op)
      OP_R, OP_ADDI, OP_ADDIU,
      OP_SLTI, OP_SLTIU: wr_rf = 1'b1;
      OP_LW:  begin is_ld = 1'b1; wr_rf = 1'b1; end
      OP_SW:  is_st = 1'b1;
      default: ;
    endcase
  end

  assign aligned = (Result[1:0] == 2'b00);
  assign ld_val  = rd_word;
  assign st_word = Rdata2;
`endif

  assign mis    = (is_ld | is_st) & ~aligned;
  assign mem_we = RST & ~Stall & In_valid & is_st & ~mis;

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[idx] <= st_word;
  end

  always_comb begin
    ov_d   = ov_q;
    data_d = data_q;
    reg_d  = reg_q;
    we_d   = we_q;
    mis_d  = mis_q;
    if (!RST) begin
      ov_d   = 1'b0;
      data_d = 32'd0;
      reg_d  = 5'd0;
      we_d   = 1'b0;
      mis_d  = 1'b0;
    end else if (!Stall) begin
      if (!In_valid) begin
        ov_d  = 1'b0;
        we_d  = 1'b0;
        mis_d = 1'b0;
      end else begin
        ov_d   = 1'b1;
        reg_d  = dest;
        mis_d  = mis;
        we_d   = wr_rf & ~mis & (dest != 5'd0);
        data_d = (is_ld & ~mis) ? ld_val : Result;
      end
    end
  end

  always_ff @(posedge CLK) begin
    ov_q   <= ov_d;
    data_q <= data_d;
    reg_q  <= reg_d;
    we_q   <= we_d;
    mis_q  <= mis_d;
  end

  assign Out_valid = ov_q;
  assign Wb_data   = data_q;
  assign Wb_reg    = reg_q;
  assign Wb_we     = we_q;
  assign Misalign  = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized traffic
// checked against a byte-array reference model.
module tb_mem_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic        In_valid;
  logic        Stall;
  logic [31:0] Ins;
  logic [31:0] Result;
  logic [31:0] Rdata2;
  logic        Out_valid;
  logic [31:0] Wb_data;
  logic [4:0]  Wb_reg;
  logic        Wb_we;
  logic        Misalign;

  int nvec = 0;
  int nerr = 0;

  mem_stage #(.ADDR_W(10)) dut (
    .CLK(CLK), .RST(RST), .In_valid(In_valid), .Stall(Stall),
    .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .Out_valid(Out_valid), .Wb_data(Wb_data), .Wb_reg(Wb_reg),
    .Wb_we(Wb_we), .Misalign(Misalign)
  );

  always #5 CLK = ~CLK;

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000;
  localparam logic [5:0] ADDIU = 6'b001001, SLTI = 6'b001010;
  localparam logic [5:0] SLTIU = 6'b001011, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, LB = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100, LH = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101, SB = 6'b101000;
  localparam logic [5:0] SH = 6'b101001;

  // reference model: 4 KiB byte-addressed memory
  logic [7:0]  mb [4096];
  logic        e_ov, e_we, e_mis;
  logic [31:0] e_data;
  logic [4:0]  e_reg;
  logic        e_listed, e_chkdata;

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {op, 5'd0, rt, rd, 11'd0};
  endfunction

  task automatic model_step(input logic rst, input logic stall,
                            input logic vld, input logic [31:0] ins,
                            input logic [31:0] res,
                            input logic [31:0] rd2);
    logic [5:0] op;
    logic [4:0] dest;
    int size, a;
    bit alu, ld, st, sgn;
    logic [31:0] v;
    if (!rst) begin
      e_ov = 0; e_we = 0; e_mis = 0; e_data = 0; e_reg = 0;
      e_listed = 1; e_chkdata = 1;
    end else if (stall) begin
    end else if (!vld) begin
      e_ov = 0; e_we = 0; e_mis = 0; e_listed = 1;
    end else begin
      op = ins[31:26];
      dest = (op == R) ? ins[15:11] : ins[20:16];
      alu = op inside {R, ADDI, ADDIU, SLTI, SLTIU};
      ld = 0; st = 0; sgn = 0; size = 4;
      if (op == LW) ld = 1;
      if (op == SW) st = 1;
`ifdef MEM_SUBWORD_EN
      if (op == LB)  begin ld = 1; size = 1; sgn = 1; end
      if (op == LBU) begin ld = 1; size = 1; end
      if (op == LH)  begin ld = 1; size = 2; sgn = 1; end
      if (op == LHU) begin ld = 1; size = 2; end
      if (op == SB)  begin st = 1; size = 1; end
      if (op == SH)  begin st = 1; size = 2; end
`endif
      a = int'(res % 4096);
      e_listed = alu || ld || st;
      e_mis = (ld || st) && (a % size != 0);
      e_ov = 1;
      e_reg = dest;
      e_we = (alu || ld) && !e_mis && dest != 0;
      e_data = res;
      e_chkdata = e_listed && !e_mis;
      if (ld && !e_mis) begin
        v = 0;
        for (int k = 0; k < size; k++) v = v | (32'(mb[a+k]) << (8*k));
        if (sgn && v[8*size-1] && size < 4) v = v - (32'd1 << (8*size));
        e_data = v;
      end
      if (st && !e_mis)
        for (int k = 0; k < size; k++) mb[a+k] = 8'(rd2 >> (8*k));
    end
  endtask

  task automatic cyc(input logic rst, input logic stall, input logic vld,
                     input logic [31:0] ins, input logic [31:0] res,
                     input logic [31:0] rd2);
    RST = rst; Stall = stall; In_valid = vld;
    Ins = ins; Result = res; Rdata2 = rd2;
    @(posedge CLK);
    model_step(rst, stall, vld, ins, res, rd2);
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 0, 1, mk(SW, 1, 0), 32'h40, 32'h1234_5678);
    cyc(0, 0, 1, mk(R, 0, 7), 32'h55, 0);
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if ({Out_valid, Wb_we, Misalign, Wb_reg, Wb_data} !== 40'd0) begin
        nerr++;
        $display("FAIL reset[%0d]: got ov=%b we=%b mis=%b reg=%0d data=%h, want all 0",
                 i, Out_valid, Wb_we, Misalign, Wb_reg, Wb_data);
      end
      cyc(1, 0, 0, mk(R, 0, 9), 32'h99, 0);
    end
  endtask

  task automatic test_preload;
    for (int i = 0; i < 1024; i++) begin
      cyc(1, 0, 1, mk(SW, 0, 0), i * 4, $urandom);
      if (i == 1023) begin
        nvec++;
        if ({Out_valid, Wb_we, Misalign, Wb_data} !== {3'b100, 32'(i * 4)}) begin
          nerr++;
          $display("FAIL preload_sw: got ov=%b we=%b mis=%b data=%h, want 1 0 0 %h",
                   Out_valid, Wb_we, Misalign, Wb_data, i * 4);
        end
      end
    end
  endtask

  task automatic test_reset_discard;
    cyc(0, 0, 1, mk(SW, 0, 0), 32'h40, 32'hCAFE_F00D);
    cyc(1, 0, 1, mk(LW, 4, 0), 32'h40, 0);
    nvec++;
    if (Wb_data !== e_data || Wb_data === 32'hCAFE_F00D) begin
      nerr++;
      $display("FAIL reset_discard: got %h, want %h", Wb_data, e_data);
    end
  endtask

  task automatic test_store_load;
    cyc(1, 0, 1, mk(SW, 9, 0), 32'h10, 32'hDEAD_BEEF);
    nvec++;
    if ({Out_valid, Wb_we, Misalign, Wb_data} !== {3'b100, 32'h10}) begin
      nerr++;
      $display("FAIL sw_out: got ov=%b we=%b mis=%b data=%h, want 1 0 0 00000010",
               Out_valid, Wb_we, Misalign, Wb_data);
    end
    cyc(1, 0, 1, mk(LW, 8, 0), 32'h10, 0);
    nvec++;
    if ({Out_valid, Wb_we, Wb_reg, Wb_data} !== {2'b11, 5'd8, 32'hDEAD_BEEF}) begin
      nerr++;
      $display("FAIL lw_after_sw: got ov=%b we=%b reg=%0d data=%h, want 1 1 8 deadbeef",
               Out_valid, Wb_we, Wb_reg, Wb_data);
    end
  endtask

  task automatic test_passthrough;
    cyc(1, 0, 1, mk(R, 1, 3), 32'h1234_5678, 0);
    nvec++;
    if ({Out_valid, Wb_we, Wb_reg, Wb_data} !== {2'b11, 5'd3, 32'h1234_5678}) begin
      nerr++;
      $display("FAIL add_pass: got ov=%b we=%b reg=%0d data=%h, want 1 1 3 12345678",
               Out_valid, Wb_we, Wb_reg, Wb_data);
    end
    cyc(1, 0, 1, mk(ADDI, 0, 5), 32'hABCD, 0);
    nvec++;
    if ({Out_valid, Wb_we, Wb_reg, Wb_data} !== {2'b10, 5'd0, 32'hABCD}) begin
      nerr++;
      $display("FAIL addi_r0: got ov=%b we=%b reg=%0d data=%h, want 1 0 0 0000abcd",
               Out_valid, Wb_we, Wb_reg, Wb_data);
    end
    cyc(1, 0, 1, mk(SLTIU, 17, 0), 32'h1, 0);
    cyc(1, 0, 0, mk(R, 2, 30), 32'hFFFF, 0);
    nvec++;
    if ({Out_valid, Wb_we, Misalign, Wb_reg, Wb_data} !== {3'b000, 5'd17, 32'h1}) begin
      nerr++;
      $display("FAIL bubble_hold: got ov=%b we=%b mis=%b reg=%0d data=%h, want 0 0 0 17 00000001",
               Out_valid, Wb_we, Misalign, Wb_reg, Wb_data);
    end
  endtask

  task automatic test_misalign_wrap;
    cyc(1, 0, 1, mk(SW, 0, 0), 32'h10, 32'h1111_1111);
    cyc(1, 0, 1, mk(SW, 0, 0), 32'h13, 32'h2222_2222);
    nvec++;
    if ({Out_valid, Wb_we, Misalign} !== 3'b101) begin
      nerr++;
      $display("FAIL sw_misalign: got ov=%b we=%b mis=%b, want 1 0 1",
               Out_valid, Wb_we, Misalign);
    end
    cyc(1, 0, 1, mk(LW, 6, 0), 32'h10, 0);
    nvec++;
    if ({Misalign, Wb_we, Wb_data} !== {2'b01, 32'h1111_1111}) begin
      nerr++;
      $display("FAIL lw_after_misalign: got mis=%b we=%b data=%h, want 0 1 11111111",
               Misalign, Wb_we, Wb_data);
    end
    cyc(1, 0, 1, mk(LW, 6, 0), 32'h12, 0);
    nvec++;
    if ({Out_valid, Wb_we, Misalign} !== 3'b101) begin
      nerr++;
      $display("FAIL lw_misalign: got ov=%b we=%b mis=%b, want 1 0 1",
               Out_valid, Wb_we, Misalign);
    end
    cyc(1, 0, 1, mk(SW, 0, 0), 32'h1000, 32'h5A5A_1234);
    cyc(1, 0, 1, mk(LW, 2, 0), 32'h0, 0);
    nvec++;
    if ({Misalign, Wb_data} !== {1'b0, 32'h5A5A_1234}) begin
      nerr++;
      $display("FAIL wrap: got mis=%b data=%h, want 0 5a5a1234", Misalign, Wb_data);
    end
  endtask

  task automatic test_stall;
    logic [31:0] old;
    cyc(1, 0, 1, mk(LW, 1, 0), 32'h30, 0);
    old = Wb_data;
    cyc(1, 0, 1, mk(R, 0, 5), 32'h55, 0);
    cyc(1, 1, 1, mk(SW, 0, 0), 32'h30, 32'h7777_0000);
    cyc(1, 1, 1, mk(SW, 0, 0), 32'h30, 32'h7777_0000);
    nvec++;
    if ({Out_valid, Wb_we, Wb_reg, Wb_data} !== {2'b11, 5'd5, 32'h55}) begin
      nerr++;
      $display("FAIL stall_hold: got ov=%b we=%b reg=%0d data=%h, want 1 1 5 00000055",
               Out_valid, Wb_we, Wb_reg, Wb_data);
    end
    cyc(1, 0, 1, mk(LW, 1, 0), 32'h30, 0);
    nvec++;
    if (Wb_data !== old) begin
      nerr++;
      $display("FAIL stall_no_write: got %h, want %h", Wb_data, old);
    end
    cyc(1, 1, 1, mk(SW, 0, 0), 32'h30, 32'h7777_0000);
    cyc(1, 0, 1, mk(SW, 0, 0), 32'h30, 32'h7777_0000);
    nvec++;
    if ({Out_valid, Wb_we, Wb_data} !== {2'b10, 32'h30}) begin
      nerr++;
      $display("FAIL stall_release: got ov=%b we=%b data=%h, want 1 0 00000030",
               Out_valid, Wb_we, Wb_data);
    end
    cyc(1, 0, 1, mk(LW, 1, 0), 32'h30, 0);
    nvec++;
    if (Wb_data !== 32'h7777_0000) begin
      nerr++;
      $display("FAIL stall_commit: got %h, want 77770000", Wb_data);
    end
  endtask

  task automatic test_subword;
    cyc(1, 0, 1, mk(SW, 0, 0), 32'h20, 32'h80FF_7F01);
`ifdef MEM_SUBWORD_EN
    cyc(1, 0, 1, mk(LB, 3, 0), 32'h23, 0);
    nvec++;
    if ({Wb_we, Misalign, Wb_data} !== {2'b10, 32'hFFFF_FF80}) begin
      nerr++;
      $display("FAIL lb: got we=%b mis=%b data=%h, want 1 0 ffffff80",
               Wb_we, Misalign, Wb_data);
    end
    cyc(1, 0, 1, mk(LBU, 3, 0), 32'h23, 0);
    nvec++;
    if (Wb_data !== 32'h0000_0080) begin
      nerr++;
      $display("FAIL lbu: got %h, want 00000080", Wb_data);
    end
    cyc(1, 0, 1, mk(LH, 3, 0), 32'h22, 0);
    nvec++;
    if (Wb_data !== 32'hFFFF_80FF) begin
      nerr++;
      $display("FAIL lh: got %h, want ffff80ff", Wb_data);
    end
    cyc(1, 0, 1, mk(LH, 3, 0), 32'h21, 0);
    nvec++;
    if ({Wb_we, Misalign} !== 2'b01) begin
      nerr++;
      $display("FAIL lh_misalign: got we=%b mis=%b, want 0 1", Wb_we, Misalign);
    end
    cyc(1, 0, 1, mk(SB, 0, 0), 32'h21, 32'h1234_56AA);
    cyc(1, 0, 1, mk(LW, 3, 0), 32'h20, 0);
    nvec++;
    if (Wb_data !== 32'h80FF_AA01) begin
      nerr++;
      $display("FAIL sb_merge: got %h, want 80ffaa01", Wb_data);
    end
`else
    cyc(1, 0, 1, mk(SB, 0, 0), 32'h21, 32'h0000_00AA);
    nvec++;
    if ({Wb_we, Misalign} !== 2'b00) begin
      nerr++;
      $display("FAIL sb_off: got we=%b mis=%b, want 0 0", Wb_we, Misalign);
    end
    cyc(1, 0, 1, mk(LB, 3, 0), 32'h23, 0);
    nvec++;
    if ({Wb_we, Misalign} !== 2'b00) begin
      nerr++;
      $display("FAIL lb_off: got we=%b mis=%b, want 0 0", Wb_we, Misalign);
    end
    cyc(1, 0, 1, mk(LW, 3, 0), 32'h20, 0);
    nvec++;
    if (Wb_data !== 32'h80FF_7F01) begin
      nerr++;
      $display("FAIL sb_off_nowrite: got %h, want 80ff7f01", Wb_data);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [5:0] ops [16];
    logic [5:0] op;
    logic [31:0] res, ins;
    logic rst, stl, vld;
    ops = '{R, ADDI, ADDIU, SLTI, SLTIU, LW, SW, LW, SW,
            LB, LBU, LH, LHU, SB, SH, 6'b001111};
    for (int i = 0; i < 3000; i++) begin
      op  = ops[$urandom_range(0, 15)];
      ins = {op, 26'($urandom)};
      res = ($urandom << 12) | (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 9) < 3) res[1:0] = 2'($urandom);
      rst = ($urandom_range(0, 99) >= 3);
      stl = ($urandom_range(0, 9) == 0);
      vld = ($urandom_range(0, 9) != 0);
      cyc(rst, stl, vld, ins, res, $urandom);
      nvec++;
      if (Wb_we !== e_we || Misalign !== e_mis ||
          (e_listed && Out_valid !== e_ov)) begin
        nerr++;
        $display("FAIL rnd_ctrl[%0d]: got ov=%b we=%b mis=%b, want %b %b %b",
                 i, Out_valid, Wb_we, Misalign, e_ov, e_we, e_mis);
      end
      if (e_listed) begin
        nvec++;
        if (Wb_reg !== e_reg) begin
          nerr++;
          $display("FAIL rnd_reg[%0d]: got %0d, want %0d", i, Wb_reg, e_reg);
        end
      end
      if (e_chkdata) begin
        nvec++;
        if (Wb_data !== e_data) begin
          nerr++;
          $display("FAIL rnd_data[%0d]: got %h, want %h", i, Wb_data, e_data);
        end
      end
    end
  endtask

  initial begin
    e_ov = 0; e_we = 0; e_mis = 0; e_data = 0; e_reg = 0;
    e_listed = 0; e_chkdata = 0;
    test_reset;
    test_preload;
    test_reset_discard;
    test_store_load;
    test_passthrough;
    test_misalign_wrap;
    test_stall;
    test_subword;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline memory stage, directly downstream of the execute stage.
- Consumes the executed instruction word, the 32-bit ALU result and the second register operand.
- Owns a word-addressed data RAM, performs loads and stores, and registers the writeback bundle (data, destination register, write enable) for the WB stage.
- Non-memory instructions pass the ALU result through to writeback with one cycle of latency.

Parameters:
- ADDR_W, 10, word-address width; RAM depth is 2**ADDR_W 32-bit words.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous, active-low reset.
- In_valid  input  1  the inputs carry a real instruction this cycle; 0 means bubble.
- Stall  input  1  hold the stage; no state change this cycle.
- Ins  input  32  instruction word from execute.
- Result  input  32  ALU result from execute; this is the byte address for loads and stores.
- Rdata2  input  32  rt operand; this is the store data.
- Out_valid  output  1  the writeback bundle is valid.
- Wb_data  output  32  writeback value.
- Wb_reg  output  5  destination register number.
- Wb_we  output  1  register-file write enable.
- Misalign  output  1  one-cycle flag for a misaligned access.

Behaviour:
- Decode:
  - op = Ins[31:26].
  - R_FORM=000000: dest = Ins[15:11].
  - All other opcodes: dest = Ins[20:16].
- Writing opcodes:
  - R_FORM, ADDI=001000, ADDIU=001001, SLTI=001010, SLTIU=001011, LW=100011.
  - SW=101011 writes no register.
  - Unlisted opcodes: writeback disabled, no memory access.
- Word index = Result[ADDR_W+1:2]. Result[31:ADDR_W+2] is ignored, so addresses wrap modulo the RAM size.
- Reset (RST=0 at posedge):
  - Out_valid=0, Wb_data=0, Wb_reg=0, Wb_we=0, Misalign=0.
  - RAM contents are not cleared.
  - A store presented in the reset cycle is discarded.
- Stall=1 at posedge (and RST=1): RAM is not written and all outputs hold their values. Stall has priority over In_valid.
- In_valid=0, Stall=0: Out_valid=0, Wb_we=0, Misalign=0; Wb_data and Wb_reg hold.
- In_valid=1, Stall=0, latency 1 (outputs reflect inputs sampled at the same posedge):
  - SW, aligned (Result[1:0]=00): RAM[idx] <= Rdata2; Wb_we=0; Wb_data=Result.
  - LW, aligned: Wb_data = RAM[idx], read from the array state before the edge; Wb_we = (dest!=0).
  - Other writing opcodes: Wb_data=Result; Wb_we = (dest!=0).
  - Writes to $0 are always suppressed (Wb_we=0).
  - Out_valid=1 and Wb_reg=dest in every case above.
- Misaligned LW/SW (Result[1:0]!=00, subword disabled):
  - No RAM write; Wb_we=0; Misalign=1 for exactly that cycle; Out_valid=1.
- Back-to-back accesses:
  - SW at edge N followed by LW to the same word at edge N+1 returns the new data.
  - Only one instruction enters per cycle, so no same-cycle read/write conflict exists.
- Misalign is 0 whenever the current output is not a misaligned access.

Optional Feature:
- Macro MEM_SUBWORD_EN.
- Defined: adds LB=100000, LBU=100100, LH=100001, LHU=100101, SB=101000, SH=101001.
  - Little-endian byte lanes.
  - Byte accesses are never misaligned.
  - Halfword accesses require Result[0]=0.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - SB and SH modify only the addressed lanes.
  - LW/SW alignment rules are unchanged.
- Undefined: these opcodes are treated as unlisted (no access, Wb_we=0, Misalign=0).

Test Plan:
- Reset then idle: RST=0 for 2 cycles, then In_valid=0 -> all outputs 0; Out_valid stays 0.
- Store then load: SW Result=0x10, Rdata2=0xDEADBEEF; next cycle LW rt=8, Result=0x10 -> LW output cycle shows Wb_data=0xDEADBEEF, Wb_reg=8, Wb_we=1, Out_valid=1.
- ALU passthrough: ADD rd=3 Result=0x12345678 -> Wb_data=0x12345678, Wb_reg=3, Wb_we=1. ADDI rt=0 -> Wb_we=0.
- Misaligned and wrap:
  - SW Result=0x13 -> Misalign=1 for one cycle; a subsequent LW of 0x10 still returns the prior data.
  - SW to Result=0x1000 then LW of 0x0 (ADDR_W=10) -> LW returns the stored data.
- Stall: assert Stall during an SW -> RAM unchanged and outputs held. Release Stall -> the same SW commits.
- MEM_SUBWORD_EN:
  - Word 0x80FF7F01 at 0x20: LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x22 -> 0xFFFF80FF.
  - SB 0x21 with data 0xAA -> word becomes 0x80FFAA01.
